// File: rtl/memory_bus_arbiter_if.sv
// Handshake bundle between the two requesters, the arbiter and the shared memory port.
// The arbiter uses the slave modport; whoever drives requests and models memory uses master.
interface memory_bus_arbiter_if #(
  parameter int ADDRESS_SIZE = 15,
  parameter int DATA_WIDTH   = 32
);
  logic                    req0;
  logic                    req1;
  logic                    write0;
  logic                    write1;
  logic [ADDRESS_SIZE-1:0] address0;
  logic [ADDRESS_SIZE-1:0] address1;
  logic [DATA_WIDTH-1:0]   dataWrite0;
  logic [DATA_WIDTH-1:0]   dataWrite1;
  logic                    ack0;
  logic                    ack1;
  logic [DATA_WIDTH-1:0]   dataRead0;
  logic [DATA_WIDTH-1:0]   dataRead1;
  logic                    memValid;
  logic                    memWrite;
  logic [ADDRESS_SIZE-1:0] memAddress;
  logic [DATA_WIDTH-1:0]   memDataWrite;
  logic                    memReady;
  logic [DATA_WIDTH-1:0]   memDataRead;
  logic                    owner;

  modport slave (
    input  req0, req1, write0, write1, address0, address1, dataWrite0, dataWrite1,
    input  memReady, memDataRead,
    output ack0, ack1, dataRead0, dataRead1,
    output memValid, memWrite, memAddress, memDataWrite, owner
  );

  modport master (
    output req0, req1, write0, write1, address0, address1, dataWrite0, dataWrite1,
    output memReady, memDataRead,
    input  ack0, ack1, dataRead0, dataRead1,
    input  memValid, memWrite, memAddress, memDataWrite, owner
  );
endinterface

// File: rtl/memory_bus_arbiter.sv
// Two-port arbiter (core = port 0, debug/DMA = port 1) in front of one memory port.
// Define MEM_ARB_ROUND_ROBIN_EN for alternating tie-break; default is fixed priority to port 0.
module memory_bus_arbiter #(
  parameter int ADDRESS_SIZE = 15,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  memory_bus_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic                    grant;
  logic                    grant1;

  logic                    mem_valid;
  logic                    mem_write;
  logic [ADDRESS_SIZE-1:0] mem_address;
  logic [DATA_WIDTH-1:0]   mem_data_write;
  logic                    ack0;
  logic                    ack1;
  logic [DATA_WIDTH-1:0]   data_read0;
  logic [DATA_WIDTH-1:0]   data_read1;
  logic                    owner;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_grant;

  // Reset to 1 so that port 0 wins the first tie after reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (grant) begin
      last_grant <= grant1;
    end
  end

  always_comb begin
    grant1 = bus.req1 & (~bus.req0 | ~last_grant);
  end
`else
  always_comb begin
    grant1 = bus.req1 & ~bus.req0;
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    grant      = 1'b0;
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          grant      = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (bus.memReady) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Acks default low each cycle, so the pulse set on completion lasts exactly the DONE cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_valid      <= 1'b0;
      mem_write      <= 1'b0;
      mem_address    <= '0;
      mem_data_write <= '0;
      ack0           <= 1'b0;
      ack1           <= 1'b0;
      data_read0     <= '0;
      data_read1     <= '0;
      owner          <= 1'b0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            mem_valid      <= 1'b1;
            owner          <= grant1;
            mem_write      <= grant1 ? bus.write1     : bus.write0;
            mem_address    <= grant1 ? bus.address1   : bus.address0;
            mem_data_write <= grant1 ? bus.dataWrite1 : bus.dataWrite0;
          end
        end
        BUSY: begin
          if (bus.memReady) begin
            mem_valid <= 1'b0;
            if (owner) begin
              data_read1 <= bus.memDataRead;
              ack1       <= 1'b1;
            end else begin
              data_read0 <= bus.memDataRead;
              ack0       <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.memValid     = mem_valid;
  assign bus.memWrite     = mem_write;
  assign bus.memAddress   = mem_address;
  assign bus.memDataWrite = mem_data_write;
  assign bus.ack0         = ack0;
  assign bus.ack1         = ack1;
  assign bus.dataRead0    = data_read0;
  assign bus.dataRead1    = data_read1;
  assign bus.owner        = owner;

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Bench for memory_bus_arbiter: vector table plus contention, drop, idle-ready and reset sequences.
// Expected accesses are queued when requests are driven and checked when an ack appears.
module tb_memory_bus_arbiter;
  localparam int AW = 15;
  localparam int DW = 32;

  typedef struct {
    bit              r0;
    bit              r1;
    bit              w0;
    bit              w1;
    logic [AW-1:0]   a0;
    logic [AW-1:0]   a1;
    logic [DW-1:0]   d0;
    logic [DW-1:0]   d1;
    int unsigned     delay;
    logic [DW-1:0]   rbase;
    bit              exp_owner;
    logic [DW-1:0]   exp_rdata;
  } vec_t;

  typedef struct {
    bit              owner;
    bit              write;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   wdata;
    logic [DW-1:0]   rdata;
    int unsigned     vcycles;
  } exp_t;

  logic clock;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  exp_t            sb[$];
  logic [DW-1:0]   exp_dr[2];
  int unsigned     mem_delay;
  logic [DW-1:0]   mem_rdata;
  bit              idle_poke;

  memory_bus_arbiter_if #(.ADDRESS_SIZE(AW), .DATA_WIDTH(DW)) bus ();

  memory_bus_arbiter #(.ADDRESS_SIZE(AW), .DATA_WIDTH(DW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic wait_acks(input string name, input int unsigned limit);
    int unsigned n = 0;
    while (sb.size() != 0 && n < limit) begin
      @(posedge clock); #2;
      n++;
    end
    check({name, "_pending"}, 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  task automatic wait_valid(input string name);
    int unsigned n = 0;
    while (!bus.memValid && n < 10) begin
      @(posedge clock); #2;
      n++;
    end
    check(name, 64'(bus.memValid), 64'd1);
  endtask

  // Memory model: answers memDelay cycles after memValid rises; read data mixes in the address.
  initial begin
    int unsigned cnt;
    cnt = 0;
    bus.memReady    = 1'b0;
    bus.memDataRead = '0;
    forever begin
      @(posedge clock); #1;
      if (bus.memValid) begin
        bus.memReady = (cnt == mem_delay);
        cnt++;
      end else begin
        bus.memReady = idle_poke;
        cnt = 0;
      end
      bus.memDataRead = bus.memReady ? (mem_rdata ^ DW'(bus.memAddress)) : 32'h0BAD_F00D;
    end
  end

  // Monitor: checks mem-side hold while valid and every ack against the scoreboard.
  initial begin
    int unsigned   vcnt;
    bit            prev_ack;
    bit            cap_w;
    logic [AW-1:0] cap_a;
    logic [DW-1:0] cap_d;
    exp_t          e;
    vcnt = 0; prev_ack = 0; cap_w = 0; cap_a = '0; cap_d = '0;
    forever begin
      @(posedge clock); #1;
      if (reset) begin
        vcnt = 0;
        prev_ack = 0;
        exp_dr[0] = '0;
        exp_dr[1] = '0;
        sb.delete();
      end else begin
        if (bus.memValid) begin
          if (vcnt == 0) begin
            cap_w = bus.memWrite;
            cap_a = bus.memAddress;
            cap_d = bus.memDataWrite;
          end else begin
            check("mem_hold", {bus.memWrite, bus.memAddress, bus.memDataWrite}, {cap_w, cap_a, cap_d});
          end
          vcnt++;
        end
        if (bus.ack0 || bus.ack1) begin
          check("ack_width", 64'(prev_ack), 64'd0);
          if (sb.size() == 0) begin
            check("unexpected_ack", {bus.ack1, bus.ack0}, 2'b00);
          end else begin
            e = sb.pop_front();
            exp_dr[e.owner] = e.rdata;
            check("ack_port", {bus.ack1, bus.ack0}, e.owner ? 2'b10 : 2'b01);
            check("owner", 64'(bus.owner), 64'(e.owner));
            check("mem_write", 64'(cap_w), 64'(e.write));
            check("mem_addr", 64'(cap_a), 64'(e.addr));
            check("mem_wdata", 64'(cap_d), 64'(e.wdata));
            check("busy_len", 64'(vcnt), 64'(e.vcycles));
            check("data_read0", 64'(bus.dataRead0), 64'(exp_dr[0]));
            check("data_read1", 64'(bus.dataRead1), 64'(exp_dr[1]));
          end
          vcnt = 0;
        end
        prev_ack = bus.ack0 | bus.ack1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[6];
    vec_t v;
    exp_t e;
    bit   seq[6];

    bus.req0 = 0; bus.req1 = 0; bus.write0 = 0; bus.write1 = 0;
    bus.address0 = '0; bus.address1 = '0; bus.dataWrite0 = '0; bus.dataWrite1 = '0;
    mem_delay = 0; mem_rdata = '0; idle_poke = 0;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #2;
    check("rst_mem_valid", 64'(bus.memValid), 64'd0);
    check("rst_mem_write", 64'(bus.memWrite), 64'd0);
    check("rst_acks", {bus.ack1, bus.ack0}, 2'b00);
    check("rst_owner", 64'(bus.owner), 64'd0);
    check("rst_mem_addr", 64'(bus.memAddress), 64'd0);
    check("rst_mem_wdata", 64'(bus.memDataWrite), 64'd0);
    check("rst_data_read", {bus.dataRead1, bus.dataRead0}, 64'd0);
    reset = 1'b0;
    @(posedge clock); #2;

    tbl[0] = '{r0:1, r1:0, w0:0, w1:0, a0:15'h0000, a1:15'h0777, d0:32'h0, d1:32'h0,
               delay:1, rbase:32'hDEADBEEF, exp_owner:0, exp_rdata:32'hDEADBEEF};
    tbl[1] = '{r0:0, r1:1, w0:0, w1:1, a0:15'h0001, a1:15'h1234, d0:32'h0, d1:32'hA5A5A5A5,
               delay:4, rbase:32'h0, exp_owner:1, exp_rdata:32'h00001234};
    tbl[2] = '{r0:1, r1:0, w0:1, w1:0, a0:15'h7FFF, a1:15'h0002, d0:32'hFFFFFFFF, d1:32'h0,
               delay:0, rbase:32'h11110000, exp_owner:0, exp_rdata:32'h11117FFF};
    tbl[3] = '{r0:0, r1:1, w0:0, w1:0, a0:15'h0003, a1:15'h0000, d0:32'h0, d1:32'h0,
               delay:0, rbase:32'h12345678, exp_owner:1, exp_rdata:32'h12345678};
    tbl[4] = '{r0:1, r1:0, w0:0, w1:0, a0:15'h0001, a1:15'h0004, d0:32'h0, d1:32'h0,
               delay:2, rbase:32'h0, exp_owner:0, exp_rdata:32'h00000001};
`ifdef MEM_ARB_ROUND_ROBIN_EN
    tbl[5] = '{r0:1, r1:1, w0:0, w1:0, a0:15'h0010, a1:15'h0020, d0:32'h0, d1:32'h0,
               delay:1, rbase:32'hCAFE0000, exp_owner:1, exp_rdata:32'hCAFE0020};
    seq = '{0, 1, 0, 1, 0, 1};
`else
    tbl[5] = '{r0:1, r1:1, w0:0, w1:0, a0:15'h0010, a1:15'h0020, d0:32'h0, d1:32'h0,
               delay:1, rbase:32'hCAFE0000, exp_owner:0, exp_rdata:32'hCAFE0010};
    seq = '{0, 0, 0, 0, 0, 0};
`endif

    for (int i = 0; i < 6; i++) begin
      v = tbl[i];
      bus.write0 = v.w0; bus.write1 = v.w1;
      bus.address0 = v.a0; bus.address1 = v.a1;
      bus.dataWrite0 = v.d0; bus.dataWrite1 = v.d1;
      mem_delay = v.delay; mem_rdata = v.rbase;
      e.owner   = v.exp_owner;
      e.write   = v.exp_owner ? v.w1 : v.w0;
      e.addr    = v.exp_owner ? v.a1 : v.a0;
      e.wdata   = v.exp_owner ? v.d1 : v.d0;
      e.rdata   = v.exp_rdata;
      e.vcycles = v.delay + 1;
      sb.push_back(e);
      bus.req0 = v.r0; bus.req1 = v.r1;
      wait_acks($sformatf("vec%0d", i), 40);
      bus.req0 = 0; bus.req1 = 0;
      repeat (2) @(posedge clock);
      #2;
    end

    // Continuous contention: six back-to-back accesses with both requests held.
    bus.write0 = 0; bus.address0 = 15'h0100; bus.dataWrite0 = 32'h00000BEE;
    bus.write1 = 1; bus.address1 = 15'h0200; bus.dataWrite1 = 32'h5555AAAA;
    mem_delay = 0; mem_rdata = '0;
    for (int i = 0; i < 6; i++) begin
      e.owner   = seq[i];
      e.write   = seq[i];
      e.addr    = seq[i] ? 15'h0200 : 15'h0100;
      e.wdata   = seq[i] ? 32'h5555AAAA : 32'h00000BEE;
      e.rdata   = seq[i] ? 32'h00000200 : 32'h00000100;
      e.vcycles = 1;
      sb.push_back(e);
    end
    bus.req0 = 1; bus.req1 = 1;
    wait_acks("contend", 60);
    bus.req0 = 0; bus.req1 = 0;
    repeat (2) @(posedge clock);
    #2;

    // Requester drops req during BUSY: access still completes once.
    bus.write0 = 0; bus.address0 = 15'h0033;
    mem_delay = 3; mem_rdata = 32'hABCD0000;
    e = '{owner:0, write:0, addr:15'h0033, wdata:32'h00000BEE, rdata:32'hABCD0033, vcycles:4};
    sb.push_back(e);
    bus.req0 = 1;
    wait_valid("drop_valid_seen");
    @(posedge clock); #2;
    bus.req0 = 0;
    wait_acks("drop", 20);
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #2;
      check("drop_no_reaccess", 64'(bus.memValid), 64'd0);
    end

    // memReady while idle must not start anything or disturb read data.
    idle_poke = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #2;
      check("idle_ready_valid", 64'(bus.memValid), 64'd0);
      check("idle_ready_acks", {bus.ack1, bus.ack0}, 2'b00);
      check("idle_ready_dr", {bus.dataRead1, bus.dataRead0}, {exp_dr[1], exp_dr[0]});
    end
    idle_poke = 0;
    @(posedge clock); #2;

    // Asynchronous reset in the middle of a long access.
    bus.write0 = 0; bus.address0 = 15'h0044;
    mem_delay = 10; mem_rdata = '0;
    bus.req0 = 1;
    wait_valid("rst_busy_valid");
    repeat (2) @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    check("rst_async_valid", 64'(bus.memValid), 64'd0);
    check("rst_async_acks", {bus.ack1, bus.ack0}, 2'b00);
    bus.req0 = 0;
    bus.req1 = 1; bus.write1 = 0; bus.address1 = 15'h0555;
    mem_delay = 1; mem_rdata = 32'h600D0000;
    repeat (2) @(posedge clock);
    #3;
    reset = 1'b0;
    e = '{owner:1, write:0, addr:15'h0555, wdata:32'h5555AAAA, rdata:32'h600D0555, vcycles:2};
    sb.push_back(e);
    wait_acks("after_reset", 20);
    bus.req1 = 0;
    repeat (3) @(posedge clock);
    #2;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
